// File: rtl/sort_input_loader_if.sv
// Loader <-> sorter bus: loaded entries,
// fill progress and start/busy/done handshake.
interface sort_input_loader_if #(
  parameter int DATA_W    = 4,
  parameter int N_ENTRIES = 4
);
  localparam int CW = $clog2(N_ENTRIES + 1);

  logic [N_ENTRIES*DATA_W-1:0] entries;
  logic [CW-1:0]               fill_count;
  logic                        sort_start;
  logic                        loading;
  logic                        sort_busy;
  logic                        sort_done;

  modport master (
    output entries,
    output fill_count,
    output sort_start,
    output loading,
    input  sort_busy,
    input  sort_done
  );

  modport slave (
    input  entries,
    input  fill_count,
    input  sort_start,
    input  loading,
    output sort_busy,
    output sort_done
  );
endinterface

// File: rtl/sort_input_loader.sv
// Debounced key capture of switch values into
// N_ENTRIES slots, then one start pulse to sorter.
module sort_input_loader #(
  parameter int DATA_W          = 4,
  parameter int N_ENTRIES       = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_n,
  input  logic [DATA_W-1:0] data_in,
  sort_input_loader_if.master bus
);

  localparam int CW    = $clog2(N_ENTRIES + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int EW    = N_ENTRIES * DATA_W;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  logic              key_s1;
  logic              key_s2;
  logic [DATA_W-1:0] data_s1;
  logic [DATA_W-1:0] data_s2;
  logic [CNT_W-1:0]  db_cnt;
  logic              db_level;
  logic              db_q;
  logic              press;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     fill_count;
  logic [CW-1:0]     fill_n;
  logic [EW-1:0]     entries;
  logic [EW-1:0]     entries_n;
  logic              sort_start;
  logic              start_n;

  // two-flop synchronisers for the raw key and switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      key_s1  <= key_n;
      key_s2  <= key_s1;
      data_s1 <= data_in;
      data_s2 <= data_s1;
    end
  end

  // level accepted only after DEBOUNCE_CYCLES stable cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_level <= 1'b1;
    end else if (key_s2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt   <= '0;
      db_level <= key_s2;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // one-cycle press pulse on the debounced falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b1;
      press <= 1'b0;
    end else begin
      db_q  <= db_level;
      press <= db_q & ~db_level;
    end
  end

  // round state, slot contents and registered start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      fill_count <= '0;
      entries    <= '0;
      sort_start <= 1'b0;
    end else begin
      state      <= state_n;
      fill_count <= fill_n;
      entries    <= entries_n;
      sort_start <= start_n;
    end
  end

  // next round state; presses outside FILL are dropped
  always_comb begin
    state_n   = state;
    fill_n    = fill_count;
    entries_n = entries;
    start_n   = 1'b0;
    unique case (state)
      FILL: begin
        if (press) begin
          for (int k = 0; k < N_ENTRIES; k++) begin
            if (fill_count == CW'(k)) begin
              entries_n[k*DATA_W +: DATA_W] = data_s2;
            end
          end
          fill_n = fill_count + CW'(1);
          if (fill_n == CW'(N_ENTRIES)) begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!bus.sort_busy) begin
          start_n = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.sort_done) begin
          state_n = FILL;
          fill_n  = '0;
        end
      end
      default: begin
        state_n = FILL;
      end
    endcase
  end

  assign bus.entries    = entries;
  assign bus.fill_count = fill_count;
  assign bus.sort_start = sort_start;
  assign bus.loading    = (state == FILL);

endmodule

// File: tb/tb_sort_input_loader.sv
// Directed bench for sort_input_loader with a
// scoreboard of expected entries/fill per capture.
module tb_sort_input_loader;

  localparam int DW = 4;
  localparam int NE = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_n = 1'b1;
  logic [DW-1:0] data_in = '0;

  sort_input_loader_if #(.DATA_W(DW), .N_ENTRIES(NE)) sif ();

  sort_input_loader #(
    .DATA_W(DW),
    .N_ENTRIES(NE),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .data_in(data_in),
    .bus(sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ent;
    int          fill;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_ent;
  int          m_fill;
  int          checks = 0;
  int          errors = 0;
  int          starts = 0;

  // count start pulses seen away from the active edge
  always @(negedge clk) begin
    if (sif.sort_start === 1'b1) starts++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // press key, push model result, wait for capture
  task automatic press_capture(input logic [DW-1:0] d);
    exp_t e;
    logic [31:0] f0;
    bit hit;
    m_ent[m_fill*DW +: DW] = d;
    m_fill++;
    e.ent  = m_ent;
    e.fill = m_fill;
    exp_q.push_back(e);
    @(negedge clk);
    data_in = d;
    key_n   = 1'b0;
    f0  = 32'(sif.fill_count);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (32'(sif.fill_count) != f0) hit = 1'b1;
    end
    e = exp_q.pop_front();
    chk("capture_seen", 32'(hit), 32'd1);
    chk("capture_entries", 32'(sif.entries), 32'(e.ent));
    chk("capture_fill", 32'(sif.fill_count), 32'(e.fill));
  endtask

  task automatic release_key();
    @(negedge clk);
    key_n = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic hold_key(input logic [DW-1:0] d, input int n);
    @(negedge clk);
    data_in = d;
    key_n   = 1'b0;
    repeat (n) @(negedge clk);
    key_n = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    int s0;
    m_ent  = '0;
    m_fill = 0;
    sif.sort_busy = 1'b0;
    sif.sort_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_entries", 32'(sif.entries), 32'h0);
    chk("rst_fill", 32'(sif.fill_count), 32'd0);
    chk("rst_loading", 32'(sif.loading), 32'd1);
    chk("rst_start", 32'(sif.sort_start), 32'd0);

    press_capture(4'h6);
    release_key();
    press_capture(4'h2);
    release_key();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_entries", 32'(sif.entries), 32'h0);
    chk("async_fill", 32'(sif.fill_count), 32'd0);
    chk("async_loading", 32'(sif.loading), 32'd1);
    chk("async_start", 32'(sif.sort_start), 32'd0);
    m_ent  = '0;
    m_fill = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    hold_key(4'h7, 3);
    chk("glitch_fill", 32'(sif.fill_count), 32'd0);
    chk("glitch_entries", 32'(sif.entries), 32'h0);

    press_capture(4'h9);
    release_key();
    press_capture(4'h3);
    release_key();
    press_capture(4'hC);
    release_key();
    s0 = starts;
    press_capture(4'h1);
    chk("issue_loading", 32'(sif.loading), 32'd0);
    @(negedge clk);
    chk("start_pulse", 32'(sif.sort_start), 32'd1);
    @(negedge clk);
    chk("start_low", 32'(sif.sort_start), 32'd0);
    release_key();
    chk("start_once", 32'(starts - s0), 32'd1);

    hold_key(4'hF, 20);
    chk("wait_entries", 32'(sif.entries), 32'h1C39);
    chk("wait_fill", 32'(sif.fill_count), 32'd4);
    sif.sort_done = 1'b1;
    @(negedge clk);
    sif.sort_done = 1'b0;
    chk("done_fill", 32'(sif.fill_count), 32'd0);
    chk("done_loading", 32'(sif.loading), 32'd1);
    m_fill = 0;
    press_capture(4'h5);
    chk("refill_entries", 32'(sif.entries), 32'h1C35);
    release_key();

    press_capture(4'hA);
    release_key();
    press_capture(4'hB);
    release_key();
    sif.sort_busy = 1'b1;
    s0 = starts;
    press_capture(4'h7);
    repeat (10) @(negedge clk);
    chk("busy_no_start", 32'(starts - s0), 32'd0);
    chk("busy_loading", 32'(sif.loading), 32'd0);
    sif.sort_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_start", 32'(sif.sort_start), 32'd1);
    @(negedge clk);
    chk("busy_start_low", 32'(sif.sort_start), 32'd0);
    release_key();
    chk("busy_start_once", 32'(starts - s0), 32'd1);

    @(negedge clk);
    key_n = 1'b0;
    repeat (7) @(negedge clk);
    sif.sort_done = 1'b1;
    @(negedge clk);
    sif.sort_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("same_fill", 32'(sif.fill_count), 32'd0);
    chk("same_entries", 32'(sif.entries), 32'h7BA5);
    chk("same_loading", 32'(sif.loading), 32'd1);
    release_key();
    m_fill = 0;
    press_capture(4'h2);
    chk("final_entries", 32'(sif.entries), 32'h7BA2);
    release_key();
    chk("total_starts", 32'(starts), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
